// File: rtl/reg_bank_write_arbiter_if.sv
// Requester-side bundle for the register-bank write arbiter: request,
// select and data inputs plus ack/err and the bank drive lines.
interface reg_bank_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int NREG = 4,
  parameter int SELW = 2,
  parameter int W    = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*SELW-1:0] sel;
  logic [NREQ*W-1:0]    wdata;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [W-1:0]         bus_data;
  logic [NREG-1:0]      reg_clk;
  logic [2:0]           grant_id;
  logic                 busy;

  modport master (
    output req, sel, wdata,
    input  ack, err, bus_data, reg_clk, grant_id, busy
  );

  modport slave (
    input  req, sel, wdata,
    output ack, err, bus_data, reg_clk, grant_id, busy
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write sequencer for a bank of 374-style octal registers on a
// shared data bus. One write per 4 cycles: grant/drive bus, raise the
// register clock, drop it and ack, then a hold cycle with the bus stable.
module reg_bank_write_arbiter #(
  parameter int NREQ = 3,
  parameter int NREG = 4,
  parameter int SELW = 2,
  parameter int W    = 8
) (
  input logic                    clk,
  input logic                    rst,
  reg_bank_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_ptr, w_ptr_nxt;
  logic [2:0]      r_gnt, w_gnt_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic [W-1:0]    r_data, w_data_nxt;
  logic [NREG-1:0] r_reg_clk, w_reg_clk_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic            r_err, w_err_nxt;
  logic            r_busy, w_busy_nxt;

  logic            w_found;
  logic [2:0]      w_pick;
  logic [SELW-1:0] w_pick_sel;
  logic [W-1:0]    w_pick_data;
  int              w_idx;

  // Per-select-code "register exists" table; avoids a range compare that
  // collapses to a constant when NREG fills the whole select space.
  logic [2**SELW-1:0] w_sel_ok;
  for (genvar g = 0; g < 2**SELW; g++) begin : g_sel_ok
    assign w_sel_ok[g] = (g < NREG) ? 1'b1 : 1'b0;
  end

  // Round-robin pick: first asserted req scanning upward from the pointer.
  always_comb begin
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_sel  = '0;
    w_pick_data = '0;
    w_idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req[w_idx]) begin
        w_found     = 1'b1;
        w_pick      = 3'(w_idx);
        w_pick_sel  = bus.sel[w_idx*SELW +: SELW];
        w_pick_data = bus.wdata[w_idx*W +: W];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_data_nxt    = r_data;
    w_busy_nxt    = r_busy;
    w_reg_clk_nxt = '0;
    w_ack_nxt     = '0;
    w_err_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_pick;
          w_sel_nxt   = w_pick_sel;
          w_data_nxt  = w_pick_data;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        // Bus has had a full cycle of setup; raise the selected clock.
        for (int i = 0; i < NREG; i++)
          w_reg_clk_nxt[i] = (r_sel == SELW'(i));
        w_state_nxt = STROBE;
      end
      STROBE: begin
        for (int i = 0; i < NREQ; i++)
          w_ack_nxt[i] = (r_gnt == 3'(i));
        w_err_nxt   = !w_sel_ok[r_sel];
        w_ptr_nxt   = (r_gnt == 3'(NREQ-1)) ? 3'd0 : r_gnt + 3'd1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        // bus_data is left alone so the register sees hold time.
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_data    <= '0;
      r_reg_clk <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_data    <= w_data_nxt;
      r_reg_clk <= w_reg_clk_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.err      = r_err;
  assign bus.bus_data = r_data;
  assign bus.reg_clk  = r_reg_clk;
  assign bus.grant_id = r_gnt;
  assign bus.busy     = r_busy;

endmodule
